// File: rtl/fazyrv_wb_arb.sv
// fazyrv_wb_arb: two-to-one Wishbone classic arbiter sharing one slave port between imem and dmem
module fazyrv_wb_arb #(
    parameter string PRIO    = "RR",
    parameter int    TIMEOUT = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        imem_cyc_i,
    input  logic        imem_stb_i,
    input  logic [31:0] imem_adr_i,
    output logic [31:0] imem_dat_o,
    output logic        imem_ack_o,
    input  logic        dmem_cyc_i,
    input  logic        dmem_stb_i,
    input  logic        dmem_we_i,
    input  logic [3:0]  dmem_be_i,
    input  logic [31:0] dmem_adr_i,
    input  logic [31:0] dmem_dat_i,
    output logic [31:0] dmem_dat_o,
    output logic        dmem_ack_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [3:0]  m_be_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    output logic        busy_o,
    output logic        timeout_o
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    state_t        state, state_n;
    logic          last_gnt;
    logic [CW-1:0] cnt;
    logic          req_i, req_d, sel_i, sel_d, expire;

    assign req_i = imem_cyc_i & imem_stb_i;
    assign req_d = dmem_cyc_i & dmem_stb_i;
    assign sel_i = (state == GNT_I) & imem_cyc_i;
    assign sel_d = (state == GNT_D) & dmem_cyc_i;

    assign m_cyc_o = sel_i | sel_d;
    assign m_stb_o = (sel_i & imem_stb_i) | (sel_d & dmem_stb_i);
    assign m_we_o  = sel_d & dmem_we_i;
    assign m_be_o  = sel_i ? 4'hF : sel_d ? dmem_be_i : 4'h0;
    assign m_adr_o = sel_i ? imem_adr_i : sel_d ? dmem_adr_i : 32'h0;
    assign m_dat_o = sel_d ? dmem_dat_i : 32'h0;

    assign expire     = (TIMEOUT > 0) && m_cyc_o && !m_ack_i && (cnt == CW'(TIMEOUT - 1));
    assign imem_ack_o = sel_i & (m_ack_i | expire);
    assign dmem_ack_o = sel_d & (m_ack_i | expire);
    assign imem_dat_o = expire ? 32'h0 : m_dat_i;
    assign dmem_dat_o = expire ? 32'h0 : m_dat_i;
    assign timeout_o  = expire;
    assign busy_o     = state != IDLE;

    // arbitrate in IDLE; release the grant on ack, abort or watchdog expiry
    always_comb begin
        state_n = state;
        if (state == IDLE)
            state_n = (req_i & req_d) ? ((PRIO == "DMEM" || !last_gnt) ? GNT_D : GNT_I) :
                      req_d ? GNT_D : req_i ? GNT_I : IDLE;
        else if (!m_cyc_o || m_ack_i || expire)
            state_n = IDLE;
    end

    // grant state, last granted master (1 = dmem) and watchdog counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            cnt      <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && state_n != IDLE)
                last_gnt <= state_n == GNT_D;
            if (state == IDLE)
                cnt <= '0;
            else if (!m_ack_i)
                cnt <= cnt + 1'b1;
        end
    end
endmodule
